// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Registered, handshaked instruction decode with a register
//               scoreboard for RAW/WAW stalls and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_BITS  = 4,
    parameter int FUNC_BITS = 4,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FUNC_BITS-1:0] out_alu_func,
    output logic                 out_alu_in2_mux,
    output logic [REG_BITS-1:0]  out_regno1,
    output logic [REG_BITS-1:0]  out_regno2,
    output logic [WORD_SIZE-1:0] out_imm,
    output logic                 out_wrt_en,
    output logic [REG_BITS-1:0]  out_wrt_regno,
    output logic                 out_illegal,
    input  logic                 wb_valid,
    input  logic [REG_BITS-1:0]  wb_regno,
    input  logic                 flush,
    output logic [CNT_BITS-1:0]  stall_cnt
);

    localparam int c_NREGS = 2 ** REG_BITS;

    logic [3:0]           w_cls;
    logic [3:0]           w_fn;
    logic [REG_BITS-1:0]  w_rd, w_rs1, w_rs2;
    logic [15:0]          w_imm16;

    assign w_cls   = in_instr[31:28];
    assign w_fn    = in_instr[27:24];
    assign w_rd    = in_instr[20 +: REG_BITS];
    assign w_rs1   = in_instr[16 +: REG_BITS];
    assign w_rs2   = in_instr[12 +: REG_BITS];
    assign w_imm16 = in_instr[15:0];

    logic [FUNC_BITS-1:0] w_func;
    logic                 w_in2_mux, w_wrt_en, w_illegal, w_is_r;
    logic [REG_BITS-1:0]  w_regno1, w_regno2, w_wrt_regno;
    logic [WORD_SIZE-1:0] w_imm;

    always_comb begin
        w_func      = '0;
        w_in2_mux   = 1'b0;
        w_wrt_en    = 1'b0;
        w_illegal   = 1'b0;
        w_is_r      = 1'b0;
        w_regno1    = '0;
        w_regno2    = '0;
        w_wrt_regno = '0;
        w_imm       = '0;
        case (w_cls)
            4'h0: begin
                w_is_r      = 1'b1;
                w_func      = w_fn[FUNC_BITS-1:0];
                w_regno1    = w_rs1;
                w_regno2    = w_rs2;
                w_wrt_regno = w_rd;
                w_wrt_en    = (w_rd != '0);
            end
            4'h1: begin
                w_func      = w_fn[FUNC_BITS-1:0];
                w_in2_mux   = 1'b1;
                w_regno1    = w_rs1;
                w_wrt_regno = w_rd;
                w_imm       = {{(WORD_SIZE-16){w_imm16[15]}}, w_imm16};
                w_wrt_en    = (w_rd != '0);
            end
            4'hF:    ;
            default: w_illegal = 1'b1;
        endcase
    end

    logic [c_NREGS-1:0] sb_q, sb_d;
    logic [c_NREGS-1:0] w_wb_mask, w_sb_eff;
    logic               w_hazard, w_accept;

    // A write-back retiring this cycle already unblocks the dependent instruction.
    assign w_wb_mask = wb_valid ? (c_NREGS'(1) << wb_regno) : '0;
    assign w_sb_eff  = sb_q & ~w_wb_mask;
    assign w_hazard  = w_sb_eff[w_rs1] | (w_is_r & w_sb_eff[w_rs2]) |
                       (w_wrt_en & w_sb_eff[w_rd]);

    logic out_valid_q, out_valid_d;
    assign in_ready = (~out_valid_q | out_ready) & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        sb_d = sb_q & ~w_wb_mask;
        if (flush && out_valid_q && out_wrt_en)
            sb_d[out_wrt_regno] = 1'b0;
        if (w_accept && w_wrt_en)
            sb_d[w_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (w_accept)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    logic [CNT_BITS-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q     <= 1'b0;
            sb_q            <= '0;
            stall_cnt_q     <= '0;
            out_alu_func    <= '0;
            out_alu_in2_mux <= 1'b0;
            out_regno1      <= '0;
            out_regno2      <= '0;
            out_imm         <= '0;
            out_wrt_en      <= 1'b0;
            out_wrt_regno   <= '0;
            out_illegal     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sb_q        <= sb_d;
            if (in_valid && w_hazard && !flush && (stall_cnt_q != {CNT_BITS{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (w_accept) begin
                out_alu_func    <= w_func;
                out_alu_in2_mux <= w_in2_mux;
                out_regno1      <= w_regno1;
                out_regno2      <= w_regno2;
                out_imm         <= w_imm;
                out_wrt_en      <= w_wrt_en;
                out_wrt_regno   <= w_wrt_regno;
                out_illegal     <= w_illegal;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int c_CNT_BITS = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_imm;
    logic [3:0]  out_alu_func, out_regno1, out_regno2, out_wrt_regno, wb_regno;
    logic        out_alu_in2_mux, out_wrt_en, out_illegal, wb_valid, flush;
    logic [c_CNT_BITS-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    decode_stage #(
        .WORD_SIZE (32),
        .REG_BITS  (4),
        .FUNC_BITS (4),
        .CNT_BITS  (c_CNT_BITS)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_func    (out_alu_func),
        .out_alu_in2_mux (out_alu_in2_mux),
        .out_regno1      (out_regno1),
        .out_regno2      (out_regno2),
        .out_imm         (out_imm),
        .out_wrt_en      (out_wrt_en),
        .out_wrt_regno   (out_wrt_regno),
        .out_illegal     (out_illegal),
        .wb_valid        (wb_valid),
        .wb_regno        (wb_regno),
        .flush           (flush),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        wb_regno  = '0;
        flush     = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_wrt_regno", 32'(out_wrt_regno), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // T1: R-type, rd=2 rs1=0 rs2=1 func=3
        in_valid = 1'b1; in_instr = 32'h0320_1200; out_ready = 1'b1;
        settle();
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_func", 32'(out_alu_func), 32'd3);
        chk("t1_regno1", 32'(out_regno1), 32'd0);
        chk("t1_regno2", 32'(out_regno2), 32'd1);
        chk("t1_wrt_regno", 32'(out_wrt_regno), 32'd2);
        chk("t1_wrt_en", 32'(out_wrt_en), 32'd1);
        chk("t1_in2_mux", 32'(out_alu_in2_mux), 32'd0);
        chk("t1_imm", out_imm, 32'd0);
        chk("t1_illegal", 32'(out_illegal), 32'd0);

        // T2: I-type, rd=3 func=5 imm=FFFE, back-to-back
        in_instr = 32'h1530_FFFE;
        tick();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_imm", out_imm, 32'hFFFF_FFFE);
        chk("t2_in2_mux", 32'(out_alu_in2_mux), 32'd1);
        chk("t2_regno2", 32'(out_regno2), 32'd0);
        chk("t2_wrt_regno", 32'(out_wrt_regno), 32'd3);
        chk("t2_func", 32'(out_alu_func), 32'd5);

        // T3: RAW on R2, then write-back bypass
        in_instr = 32'h0042_0000;
        settle();
        chk("t3_in_ready_stall", 32'(in_ready), 32'd0);
        tick();
        chk("t3_cnt1", 32'(stall_cnt), 32'd1);
        chk("t3_valid_drop", 32'(out_valid), 32'd0);
        tick();
        chk("t3_cnt2", 32'(stall_cnt), 32'd2);
        wb_valid = 1'b1; wb_regno = 4'd2;
        settle();
        chk("t3_in_ready_bypass", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_regno1", 32'(out_regno1), 32'd2);
        chk("t3_wrt_regno", 32'(out_wrt_regno), 32'd4);
        chk("t3_cnt_hold", 32'(stall_cnt), 32'd2);

        in_valid = 1'b0;
        wb_valid = 1'b1; wb_regno = 4'd3;
        tick();
        wb_regno = 4'd4;
        tick();
        wb_valid = 1'b0;

        // T4: backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0156_7000;
        tick();
        in_instr = 32'h0289_A000;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_in_ready_bp", 32'(in_ready), 32'd0);
            tick();
            chk("t4_valid_hold", 32'(out_valid), 32'd1);
            chk("t4_func_hold", 32'(out_alu_func), 32'd1);
            chk("t4_wrt_regno_hold", 32'(out_wrt_regno), 32'd5);
        end
        chk("t4_cnt", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        settle();
        chk("t4_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        chk("t4_valid_b2b", 32'(out_valid), 32'd1);
        chk("t4_func_new", 32'(out_alu_func), 32'd2);
        chk("t4_wrt_regno_new", 32'(out_wrt_regno), 32'd8);
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_regno = 4'd5;
        tick();
        chk("t4_valid_fall", 32'(out_valid), 32'd0);
        wb_regno = 4'd8;
        tick();
        wb_valid = 1'b0;

        // T5: flush a held R2 writer
        in_valid = 1'b1; in_instr = 32'h0320_1200; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        settle();
        chk("t5_in_ready_flush", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_instr = 32'h0042_0000; out_ready = 1'b1;
        settle();
        chk("t5_sb2_cleared", 32'(in_ready), 32'd1);
        in_instr = 32'h0100_0000;
        tick();
        chk("t5_r0_valid", 32'(out_valid), 32'd1);
        chk("t5_r0_wrt_en", 32'(out_wrt_en), 32'd0);
        in_instr = 32'h0000_0000;
        settle();
        chk("t5_r0_no_sb", 32'(in_ready), 32'd1);

        // T6: illegal class and NOP
        in_instr = 32'h7321_0000;
        tick();
        chk("t6_illegal", 32'(out_illegal), 32'd1);
        chk("t6_ill_wrt_en", 32'(out_wrt_en), 32'd0);
        chk("t6_ill_func", 32'(out_alu_func), 32'd0);
        chk("t6_ill_regno1", 32'(out_regno1), 32'd0);
        in_instr = 32'hF321_0000;
        tick();
        chk("t6_nop_illegal", 32'(out_illegal), 32'd0);
        chk("t6_nop_func", 32'(out_alu_func), 32'd0);
        chk("t6_nop_wrt_en", 32'(out_wrt_en), 32'd0);

        // Reset in the middle of a stall
        in_instr = 32'h0320_1200;
        tick();
        in_instr = 32'h0042_0000;
        tick();
        tick();
        chk("t6_cnt_pre_rst", 32'(stall_cnt), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("t6_rst_func", 32'(out_alu_func), 32'd0);
        chk("t6_rst_wrt_regno", 32'(out_wrt_regno), 32'd0);
        chk("t6_rst_regno1", 32'(out_regno1), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();

        // Saturation of the stall counter
        in_valid = 1'b1; in_instr = 32'h0320_1200; out_ready = 1'b1;
        tick();
        in_instr = 32'h0042_0000;
        for (int i = 0; i < 254; i++) tick();
        chk("sat_cnt_fe", 32'(stall_cnt), 32'h0000_00FE);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt_ff", 32'(stall_cnt), 32'h0000_00FF);
        chk("sat_in_ready", 32'(in_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
